// File: rtl/posit_encoder.sv
// Three-stage posit packer: builds the regime, packs and rounds to nearest-even,
// then applies sign and special values. A single stall freezes every stage.
module posit_encoder #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                Zero,
    input  logic                NaR,
    input  logic                Sign,
    input  logic signed [RS:0]  RegimeValue,
    input  logic [ES-1:0]       Exponent,
    input  logic [N-ES+2:0]     Mantissa,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        Posit
);
    localparam int FW   = N - ES + 2;
    localparam int VW   = 2*N + ES;
    localparam int LW   = $clog2(N + 1);
    localparam int KMAX = N - 2;

    typedef struct packed {
        logic [N-1:0]  rgm;
        logic [LW-1:0] len;
        logic          sat_hi;
        logic          sat_lo;
        logic [ES-1:0] exp;
        logic [FW-1:0] frac;
        logic          sign;
        logic          zero;
        logic          nar;
    } s1_t;

    typedef struct packed {
        logic [N-2:0] body;
        logic         sign;
        logic         zero;
        logic         nar;
    } s2_t;

    logic [3:1]   vld_pipe_q;
    s1_t          s1_d, s1_q;
    s2_t          s2_d, s2_q;
    logic [N-1:0] posit_d, posit_q;
    logic         stall, adv;
    logic         unused_hidden;

    // The hidden bit is implied by the regime/exponent encoding.
    assign unused_hidden = Mantissa[FW];

    assign stall     = vld_pipe_q[3] && !out_ready;
    assign adv       = !stall;
    assign in_ready  = adv;
    assign out_valid = vld_pipe_q[3];
    assign Posit     = posit_q;

    always_comb begin
        int k;
        int kc;
        s1_d        = '0;
        k           = int'(RegimeValue);
        s1_d.sat_hi = (k > KMAX);
        s1_d.sat_lo = (k < -KMAX);
        kc          = s1_d.sat_hi ? KMAX : (s1_d.sat_lo ? -KMAX : k);
        // Regime is left-aligned in rgm; bits past len stay zero.
        if (kc >= 0) begin
            s1_d.rgm = {N{1'b1}} << (N - kc - 1);
            s1_d.len = LW'(kc + 2);
        end else begin
            s1_d.rgm = {1'b1, {(N-1){1'b0}}} >> (-kc);
            s1_d.len = LW'(1 - kc);
        end
        s1_d.exp  = Exponent;
        s1_d.frac = Mantissa[FW-1:0];
        s1_d.sign = Sign;
        s1_d.zero = Zero;
        s1_d.nar  = NaR;
    end

    always_comb begin
        logic [VW-1:0]  v;
        logic [N-2:0]   body;
        logic           g, l, s, rnd;
        s2_d = '0;
        v    = {s1_q.rgm, {(VW-N){1'b0}}}
             | ({s1_q.exp, s1_q.frac, {(VW-ES-FW){1'b0}}} >> s1_q.len);
        body = v[VW-1 -: N-1];
        l    = v[VW-N+1];
        g    = v[VW-N];
        s    = |v[VW-N-1:0];
        // An all-ones body is maxpos; incrementing it would wrap into NaR.
        rnd  = g && (l || s) && !(&body);
        s2_d.body = body + (N-1)'(rnd);
        if (s1_q.sat_hi)
            s2_d.body = '1;
        else if (s1_q.sat_lo || s2_d.body == '0)
            s2_d.body = (N-1)'(1);
        s2_d.sign = s1_q.sign;
        s2_d.zero = s1_q.zero;
        s2_d.nar  = s1_q.nar;
    end

    always_comb begin
        logic [N-1:0] word;
        word    = {1'b0, s2_q.body};
        posit_d = s2_q.sign ? (~word + N'(1)) : word;
        if (s2_q.nar)
            posit_d = {1'b1, {(N-1){1'b0}}};
        else if (s2_q.zero)
            posit_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            posit_q    <= '0;
        end else if (adv) begin
            vld_pipe_q <= {vld_pipe_q[2:1], in_valid};
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            posit_q    <= posit_d;
        end
    end
endmodule

// File: tb/tb_posit_encoder.sv
// Scoreboard bench for posit_encoder (N=8, ES=3): directed encodings, backpressure,
// asynchronous reset mid-flight, then randomized traffic against a bit-string model.
module tb_posit_encoder;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic       Zero, NaR, Sign;
    logic [3:0] RegimeValue;
    logic [2:0] Exponent;
    logic [7:0] Mantissa;
    logic       out_valid, out_ready;
    logic [7:0] Posit;

    logic [7:0] sb[$];
    int         checks = 0;
    int         errors = 0;
    bit         rnd_done;

    posit_encoder #(.N(8), .ES(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Zero(Zero), .NaR(NaR), .Sign(Sign), .RegimeValue(RegimeValue),
        .Exponent(Exponent), .Mantissa(Mantissa), .out_valid(out_valid),
        .out_ready(out_ready), .Posit(Posit)
    );

    always #5 clk = ~clk;

    // Directed table: k, exponent, mantissa, sign, zero, nar, expected posit
    int         d_k[13] = '{2, 1, -2, 2, 1, 1, 1, 7, 6, -7, -7, 3, 3};
    int         d_e[13] = '{3, 5, 5, 3, 5, 5, 5, 0, 7, 0, 0, 5, 5};
    int         d_m[13] = '{'h80, 'hC0, 'hC0, 'h80, 'hE0, 'hA0, 'hB0, 'h80, 'h80, 'h80, 'h80, 'hFF, 'hFF};
    bit         d_s[13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    bit         d_z[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    bit         d_n[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [7:0] d_x[13] = '{8'h73, 8'h6B, 8'h1B, 8'h8D, 8'h6C, 8'h6A, 8'h6B,
                            8'h7F, 8'h7F, 8'h01, 8'hFF, 8'h00, 8'h80};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: lay out regime/exponent/fraction as a bit queue, then cut and round.
    function automatic logic [7:0] ref_enc(bit z, bit n, bit s, int k, int e, int m);
        bit q[$];
        int body;
        int w;
        bit g, st;
        if (n) return 8'h80;
        if (z) return 8'h00;
        if (k > 6) body = 127;
        else if (k < -6) body = 1;
        else begin
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = 2; i >= 0; i--) q.push_back(e[i]);
            for (int i = 6; i >= 0; i--) q.push_back(m[i]);
            while (q.size() < 9) q.push_back(1'b0);
            body = 0;
            for (int i = 0; i < 7; i++) body = body * 2 + int'(q[i]);
            g  = q[7];
            st = 1'b0;
            for (int i = 8; i < q.size(); i++) st |= q[i];
            if (g && ((body % 2 == 1) || st) && body != 127) body++;
            if (body == 0) body = 1;
        end
        w = s ? (256 - body) : body;
        return w[7:0];
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra got %02h want no output", Posit);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                chk("sb_posit", {24'd0, Posit}, {24'd0, e});
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a posedge; returns 1 time unit after the accepting edge.
    task automatic send(bit z, bit n, bit s, int k, int e, int m, logic [7:0] exp);
        int t;
        in_valid    = 1'b1;
        Zero        = z;
        NaR         = n;
        Sign        = s;
        RegimeValue = 4'(k);
        Exponent    = 3'(e);
        Mantissa    = 8'(m);
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got in_ready=0 want 1 within 200 cycles");
                break;
            end
        end
        sb.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_dir(int i);
        send(d_z[i], d_n[i], d_s[i], d_k[i], d_e[i], d_m[i], d_x[i]);
    endtask

    task automatic drain(string nm);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(nm, sb.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Zero = 1'b0; NaR = 1'b0; Sign = 1'b0;
        RegimeValue = '0; Exponent = '0; Mantissa = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_posit", Posit, 0);
        chk("rst_in_ready", in_ready, 1);
        sync();
        reset = 1'b0;
        sync();

        // Latency of the first item, then the rest of the table back to back.
        send_dir(0);
        @(negedge clk); chk("lat_c1", out_valid, 0);
        @(negedge clk); chk("lat_c2", out_valid, 0);
        @(negedge clk); chk("lat_c3", out_valid, 1);
        sync();
        for (int i = 1; i < 13; i++) send_dir(i);
        drain("dir_drain");

        // Backpressure: three accepts fill the pipe, then the head must hold.
        sync();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_dir(i);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", Posit, 8'h73);
        held = Posit;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", Posit, held);
            chk("bp_stall", in_ready, 0);
        end
        sync();
        out_ready = 1'b1;
        send_dir(3);
        send_dir(4);
        drain("bp_drain");

        // Asynchronous reset with a full, stalled pipe.
        sync();
        out_ready = 1'b0;
        for (int i = 1; i < 4; i++) send_dir(i);
        @(negedge clk);
        chk("rm_valid_before", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_out_valid", out_valid, 0);
        chk("rm_posit", Posit, 0);
        chk("rm_in_ready", in_ready, 1);
        sb.delete();
        sync();
        reset = 1'b0;
        out_ready = 1'b1;
        chk("rm_after_ready", in_ready, 1);
        send_dir(5);
        @(negedge clk); chk("rm_lat_c1", out_valid, 0);
        @(negedge clk); chk("rm_lat_c2", out_valid, 0);
        @(negedge clk); chk("rm_lat_c3", out_valid, 1);
        drain("rm_drain");

        // Randomized traffic with random backpressure.
        sync();
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    bit z, n, s;
                    int k, e, m;
                    if ($urandom_range(0, 3) == 0) sync();
                    z = ($urandom_range(0, 15) == 0);
                    n = ($urandom_range(0, 15) == 0);
                    s = 1'($urandom_range(0, 1));
                    k = int'($urandom_range(0, 15)) - 8;
                    e = int'($urandom_range(0, 7));
                    m = 128 + int'($urandom_range(0, 127));
                    send(z, n, s, k, e, m, ref_enc(z, n, s, k, e, m));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    sync();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("rnd_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
- Pipelined posit packer and rounder. It is the inverse of the posit field decoder that feeds Alignment.
- Input: unpacked posit fields (sign, signed regime value, exponent, mantissa with hidden bit), as produced by the core arithmetic datapath.
- Output: one N-bit two's-complement posit word, rounded to nearest-even and saturated.
- Sits at the output of the adder core. Uses a valid/ready handshake with 3-cycle latency and full-pipeline stall on backpressure.

Parameters:
- N, 8, posit word width.
- ES, 3, exponent field width.
- RS, log2(N), regime value magnitude width; regime port is RS+1 bits signed.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input fields valid.
- in_ready  output  1  encoder can accept an input this cycle.
- Zero  input  1  result is exact zero; other fields are ignored.
- NaR  input  1  result is Not-a-Real; has priority over Zero.
- Sign  input  1  1 = negative.
- RegimeValue  input  RS+1  signed regime k.
- Exponent  input  ES  exponent field.
- Mantissa  input  N-ES+3  normalised mantissa. MSB is the hidden 1; the remaining N-ES+2 bits are fraction.
- out_valid  output  1  Posit is valid.
- out_ready  input  1  downstream accepts Posit.
- Posit  output  N  encoded posit.

Behaviour:
- Reset values: out_valid=0, Posit=0, all stage valid flags=0, in_ready=1. Reset acts immediately and asynchronously.
- Reset mid-operation discards all in-flight items. No partial output is ever presented.
- Handshake:
  - Transfer in on in_valid&&in_ready.
  - Transfer out on out_valid&&out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - On stall, every stage holds its contents. Otherwise all stages advance together; bubbles advance too.
  - Posit and out_valid are stable while stalled.
  - Latency is 3 cycles from accept to out_valid when there is no stall. Throughput is 1 per cycle. Input order is preserved.
- Stage 1, regime build:
  - Clamp k into [-(N-2), N-2] and record sat_hi (k>N-2) or sat_lo (k<-(N-2)).
  - k>=0: regime field is k+1 ones followed by one 0.
  - k<0: regime field is -k zeros followed by one 1.
  - Regime length is at most N bits. Register the field, its length, the flags, Exponent, fraction bits and Sign.
- Stage 2, pack and round:
  - Form the bit string {regime, Exponent, fraction}, left-aligned in a 2N+ES-bit vector.
  - body = top N-1 bits; L = body LSB; G = next bit; S = OR of all remaining bits.
  - Round up iff G && (L||S).
  - Never increment an all-ones body, so rounding never overflows into NaR.
  - Special cases:
    - sat_hi gives body = all ones (maxpos).
    - sat_lo gives body = 0…01 (minpos).
    - A nonzero value never rounds to zero.
- Stage 3, sign apply:
  - word = {0, body}. If Sign, Posit = two's complement of word.
  - NaR gives Posit = 1 followed by N-1 zeros.
  - Zero (with NaR=0) gives Posit = all zeros.
  - Register to the output.
- Fields with Zero or NaR asserted are don't-care and must not affect the result.
- Simultaneous in and out transfer in the same cycle is allowed. Full throughput must be sustained when out_ready=1.

Test Plan (N=8, ES=3):
- Exact encodings, all Sign=0, out_ready=1:
  - k=2, Exponent=011, Mantissa=10000000 -> Posit=0x73, out_valid exactly 3 cycles after accept.
  - k=1, Exponent=101, Mantissa=11000000 -> 0x6B.
  - k=-2, Exponent=101, Mantissa=11000000 -> 0x1B.
  - Same as the first case but Sign=1 -> 0x8D.
- Rounding:
  - k=1, Exponent=101, Mantissa=11100000 (G=1, L=1) -> 0x6C.
  - Mantissa=10100000 (G=1, L=0, S=0, tie to even) -> 0x6A.
  - Mantissa=10110000 (S=1) -> 0x6B.
- Saturation and specials:
  - k=7 -> 0x7F; k=6, Exponent=111 -> 0x7F.
  - k=-7 -> 0x01; k=-7, Sign=1 -> 0xFF.
  - Zero=1 -> 0x00; NaR=1, Zero=1 -> 0x80.
- Backpressure:
  - Stream 5 inputs (the first-scenario values A..E) with out_ready=0 for 6 cycles.
  - Required: in_ready drops after 3 accepts; Posit holds stable; after out_ready=1 all 5 emerge in order with no loss or duplication.
- Reset mid-operation:
  - Assert reset with 3 items in flight during a stall -> out_valid=0 and Posit=0 immediately (asynchronous).
  - After release, in_ready=1 and the next input encodes correctly after 3 cycles.
